// File: rtl/iterative_mul_add.sv
// rtl/iterative_mul_add.sv - sequential signed a*b+c, one multiplier bit per cycle
// Shift-add over the multiplier bits; the sign bit's weight is negative, so the last step subtracts.
module iterative_mul_add #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_lo,
    output logic [DATA_WIDTH-1:0] out_hi
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  acc_next;
    logic [2*W-1:0]  result;
    logic            last_step;

    always_comb begin
        last_step = (count == LAST);
        acc_next  = acc;
        if (mplier[0]) begin
            acc_next = last_step ? (acc - mcand) : (acc + mcand);
        end
    end

    // in_ready/out_valid are flops so reset holds in_ready low until the first edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            result    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= BUSY;
                        count    <= '0;
                        mcand    <= {{W{in_a[W-1]}}, in_a};
                        mplier   <= in_b;
                        acc      <= {{W{in_c[W-1]}}, in_c};
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_step) begin
                        state     <= DONE;
                        result    <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_lo = result[W-1:0];
    assign out_hi = result[2*W-1:W];

endmodule

// File: tb/tb_iterative_mul_add.sv
// tb/tb_iterative_mul_add.sv - scoreboard bench for iterative_mul_add at W=8 and W=32
module tb_iterative_mul_add;
    logic        clock;
    logic        reset_n;

    logic        v8, r8, ov8, or8;
    logic [7:0]  a8, b8, c8, lo8, hi8;
    logic        v32, r32, ov32, or32;
    logic [31:0] a32, b32, c32, lo32, hi32;

    int vectors;
    int miscompares;

    logic [15:0] q8[$];
    logic [63:0] q32[$];

    iterative_mul_add #(.DATA_WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8), .in_c(c8),
        .out_valid(ov8), .out_ready(or8), .out_lo(lo8), .out_hi(hi8)
    );

    iterative_mul_add #(.DATA_WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32), .in_c(c32),
        .out_valid(ov32), .out_ready(or32), .out_lo(lo32), .out_hi(hi32)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [15:0] exp, output bit ok);
        int n;
        a8 = a; b8 = b; c8 = c; v8 = 1'b1;
        n = 0;
        while (!r8 && n < 50) begin
            tick();
            n++;
        end
        ok = r8;
        if (ok) begin
            q8.push_back(exp);
            tick();
        end
        v8 = 1'b0;
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (!ov8 && n < 40) begin
            tick();
            n++;
        end
        if (!ov8) n = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        v8 = 0; or8 = 0; a8 = 0; b8 = 0; c8 = 0;
        v32 = 0; or32 = 0; a32 = 0; b32 = 0; c32 = 0;
        repeat (3) tick();
        vectors++;
        if ({r8, ov8, hi8, lo8} !== 18'h0) begin
            $display("FAIL reset8: ready=%b valid=%b result=%h, required 0/0/0000", r8, ov8, {hi8, lo8});
            miscompares++;
        end
        vectors++;
        if ({r32, ov32, hi32, lo32} !== 66'h0) begin
            $display("FAIL reset32: ready=%b valid=%b result=%h, required 0/0/0", r32, ov32, {hi32, lo32});
            miscompares++;
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if (r8 !== 1'b1 || r32 !== 1'b1) begin
            $display("FAIL reset_release: ready8=%b ready32=%b, required 1/1", r8, r32);
            miscompares++;
        end
    endtask

    task automatic test_basic;
        logic [7:0]  ta[5] = '{8'h07, 8'h80, 8'h80, 8'hFB, 8'h00};
        logic [7:0]  tb[5] = '{8'h06, 8'h80, 8'h7F, 8'h03, 8'hB3};
        logic [7:0]  tc[5] = '{8'h03, 8'h00, 8'h80, 8'hFF, 8'hB3};
        logic [15:0] te[5] = '{16'h002D, 16'h4000, 16'hC000, 16'hFFF0, 16'hFFB3};
        bit ok;
        int n;
        logic [15:0] exp;
        or8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue8(ta[i], tb[i], tc[i], te[i], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL basic_accept[%0d]: in_ready never rose", i);
                miscompares++;
                continue;
            end
            wait_valid8(n);
            vectors++;
            if (n !== 8) begin
                $display("FAIL basic_latency[%0d]: %0d edges after accept, required 8", i, n);
                miscompares++;
            end
            exp = q8.pop_front();
            vectors++;
            if ({hi8, lo8} !== exp) begin
                $display("FAIL basic_result[%0d]: got %h, required %h", i, {hi8, lo8}, exp);
                miscompares++;
            end
            tick();
            vectors++;
            if (ov8 !== 1'b0 || r8 !== 1'b1) begin
                $display("FAIL basic_pulse[%0d]: valid=%b ready=%b, required 0/1", i, ov8, r8);
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        logic [15:0] held;
        logic [15:0] exp;
        or8 = 1'b0;
        issue8(8'h09, 8'hFC, 8'h05, 16'hFFE1, ok);
        wait_valid8(n);
        vectors++;
        if (n !== 8) begin
            $display("FAIL bp_latency: %0d edges, required 8", n);
            miscompares++;
        end
        a8 = 8'h0B; b8 = 8'h0B; c8 = 8'hEB; v8 = 1'b1;
        held = {hi8, lo8};
        vectors++;
        if (held !== q8[0]) begin
            $display("FAIL bp_result: got %h, required %h", held, q8[0]);
            miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ov8 !== 1'b1 || r8 !== 1'b0 || {hi8, lo8} !== held) begin
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%h, required 1/0/%h",
                         i, ov8, r8, {hi8, lo8}, held);
                miscompares++;
            end
            tick();
        end
        or8 = 1'b1;
        exp = q8.pop_front();
        vectors++;
        if (ov8 !== 1'b1 || {hi8, lo8} !== exp) begin
            $display("FAIL bp_release: valid=%b result=%h, required 1/%h", ov8, {hi8, lo8}, exp);
            miscompares++;
        end
        tick();
        vectors++;
        if (r8 !== 1'b1 || ov8 !== 1'b0) begin
            $display("FAIL bp_idle: ready=%b valid=%b, required 1/0", r8, ov8);
            miscompares++;
        end
        q8.push_back(16'h0064);
        tick();
        v8 = 1'b0;
        wait_valid8(n);
        exp = q8.pop_front();
        vectors++;
        if (n !== 8 || {hi8, lo8} !== exp) begin
            $display("FAIL bp_pending: edges=%0d result=%h, required 8/%h", n, {hi8, lo8}, exp);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_async_reset;
        bit ok;
        int n;
        logic [15:0] exp;
        or8 = 1'b1;
        issue8(8'h05, 8'h05, 8'h05, 16'h001E, ok);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({ov8, r8, hi8, lo8} !== 18'h0 || {ov32, hi32, lo32} !== 65'h0) begin
            $display("FAIL async_reset: valid=%b ready=%b result=%h result32=%h, required all 0",
                     ov8, r8, {hi8, lo8}, {hi32, lo32});
            miscompares++;
        end
        q8.delete();
        tick();
        reset_n = 1'b1;
        vectors++;
        if (r8 !== 1'b0) begin
            $display("FAIL async_release_early: ready=%b, required 0", r8);
            miscompares++;
        end
        tick();
        vectors++;
        if (r8 !== 1'b1 || ov8 !== 1'b0) begin
            $display("FAIL async_release: ready=%b valid=%b, required 1/0", r8, ov8);
            miscompares++;
        end
        issue8(8'h02, 8'h03, 8'h01, 16'h0007, ok);
        wait_valid8(n);
        exp = q8.pop_front();
        vectors++;
        if (n !== 8 || {hi8, lo8} !== exp) begin
            $display("FAIL async_next_op: edges=%0d result=%h, required 8/%h", n, {hi8, lo8}, exp);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_throughput;
        localparam int N = 1000;
        logic [31:0] qa[N];
        logic [31:0] da[N];
        logic [31:0] ra[N];
        logic [63:0] ea[N];
        int num, den, quo, rem;
        int sent, recv, cyc, last_acc;
        bit acc, del;
        logic [63:0] exp;
        qa[0] = 32'h8000_0000; da[0] = 32'hFFFF_FFFF; ra[0] = 32'h0; ea[0] = 64'h0000_0000_8000_0000;
        qa[1] = 32'h8000_0000; da[1] = 32'h0000_0001; ra[1] = 32'h0; ea[1] = 64'hFFFF_FFFF_8000_0000;
        qa[2] = 32'h8000_0001; da[2] = 32'hFFFF_FFFF; ra[2] = 32'h0; ea[2] = 64'h0000_0000_7FFF_FFFF;
        qa[3] = 32'h0000_0001; da[3] = 32'h8000_0000; ra[3] = 32'h0; ea[3] = 64'hFFFF_FFFF_8000_0000;
        qa[4] = 32'h0000_0007; da[4] = 32'hFFFF_FFFF; ra[4] = 32'h0; ea[4] = 64'hFFFF_FFFF_FFFF_FFF9;
        for (int i = 5; i < N; i++) begin
            num = $urandom;
            den = (i % 4 == 0) ? $urandom_range(0, 16) - 8 : $urandom;
            if (den == 0) den = 1;
            if (num == 32'h8000_0000 && den == -1) den = 1;
            quo = num / den;
            rem = num % den;
            qa[i] = quo; da[i] = den; ra[i] = rem;
            ea[i] = {{32{num[31]}}, num};
        end
        sent = 0; recv = 0; cyc = 0; last_acc = -1;
        a32 = qa[0]; b32 = da[0]; c32 = ra[0]; v32 = 1'b1; or32 = 1'b1;
        while (recv < N && cyc < N * 34 + 200) begin
            acc = v32 && r32;
            del = ov32 && or32;
            if (del) begin
                vectors++;
                if (q32.size() == 0) begin
                    $display("FAIL tp_unexpected: result %h with empty scoreboard", {hi32, lo32});
                    miscompares++;
                end else begin
                    exp = q32.pop_front();
                    if ({hi32, lo32} !== exp) begin
                        $display("FAIL tp_result[%0d]: got %h, required %h", recv, {hi32, lo32}, exp);
                        miscompares++;
                    end
                end
                recv++;
            end
            if (acc) begin
                q32.push_back(ea[sent]);
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc !== 34) begin
                        $display("FAIL tp_interval[%0d]: %0d cycles, required 34", sent, cyc - last_acc);
                        miscompares++;
                    end
                end
                last_acc = cyc;
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent < N) begin
                    a32 = qa[sent]; b32 = da[sent]; c32 = ra[sent];
                end else begin
                    v32 = 1'b0;
                end
            end
        end
        vectors++;
        if (recv !== N) begin
            $display("FAIL tp_count: %0d results received, required %0d", recv, N);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_async_reset();
        test_throughput();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
